// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the ID->EX hazard/flush controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } haz_state_e;

  // Bit positions inside the packed decoder control bundle
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  // Counter width able to hold max(a,b)-1 with one bit of headroom
  function automatic int haz_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between ID and EX stages
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              hazard
);

  // A load into r0 never creates a dependency; rt only matters when ID reads it
  always_comb begin
    hazard = ex_memread & (ex_rt != '0) &
             ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - ID/EX control register with branch squash and load-use stall FSM (optional HAZ_PERF_CNT_EN perf counters)
module hazard_flush_ctrl
  import hazard_pkg::*;
#(
  parameter int CTRL_W      = 9,
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int LOAD_STALL  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              branch_taken,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  localparam int CNT_W = haz_cnt_w(FLUSH_DEPTH, LOAD_STALL);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  haz_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             hazard;
  logic             squash;
  logic             stall;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .hazard     (hazard)
  );

  // Squash beats stall; hazard is only looked at from RUN
  always_comb begin
    squash = branch_taken | (state == FLUSH);
    stall  = ~squash & ((hazard & (state == RUN)) | (state == STALL));
  end

  // Pipeline enables; reset forces a frozen, flushed front end
  always_comb begin
    ifid_flush = rst | squash;
    pc_write   = ~rst & ~stall;
    ifid_write = ~rst & ~stall;
    busy       = ~rst & (state != RUN);
  end

  // FSM, down-counter and the ID/EX control register (bubble on squash or stall)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      ex_ctrl <= '0;
    end else begin
      ex_ctrl <= (squash | stall) ? '0 : id_ctrl;
      if (branch_taken) begin
        cnt   <= FLUSH_LOAD;
        state <= (FLUSH_LOAD != '0) ? FLUSH : RUN;
      end else begin
        case (state)
          RUN: begin
            if (hazard) begin
              cnt   <= STALL_LOAD;
              state <= (STALL_LOAD != '0) ? STALL : RUN;
            end
          end
          STALL, FLUSH: begin
            // The cycle that sees cnt==1 is the last one spent in this state
            if (cnt <= CNT_ONE) begin
              cnt   <= '0;
              state <= RUN;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= RUN;
          end
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counts of stalled and squashed cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (squash && (flush_cycles != 32'hFFFF_FFFF)) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule
